// File: rtl/canvas_pkg.sv
// Shared constants and state encoding for the 28x28 drawing canvas.
// The canvas writer and reader both import this so geometry stays in one place.
package canvas_pkg;

    localparam int GRID_SIZE  = 28;
    localparam int NUM_PIXELS = GRID_SIZE * GRID_SIZE;
    localparam int ADDR_W     = 10;
    localparam int COORD_W    = 5;
    localparam int COUNT_W    = 10;

    localparam logic [7:0] PIXEL_ON  = 8'd255;
    localparam logic [7:0] PIXEL_OFF = 8'd0;

    localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [COORD_W-1:0] COORD_MAX  = COORD_W'(GRID_SIZE - 1);
    // Empty bounding box: min at the top of the coordinate range, max at zero,
    // so the first set cell always overwrites both.
    localparam logic [COORD_W-1:0] BBOX_MIN_INIT = '1;
    localparam logic [COORD_W-1:0] BBOX_MAX_INIT = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/pixel_skid_fifo.sv
// Two-entry FIFO of {pixel, last, x, y}. The head entry is a register that
// drives the output port directly, so the output never changes while it waits
// for the consumer. The occupancy count feeds the reader's read-issue credit.
module pixel_skid_fifo
    import canvas_pkg::*;
(
    input  logic               clk,
    input  logic               srst,
    input  logic               push,
    input  logic               in_pixel,
    input  logic [COORD_W-1:0] in_x,
    input  logic [COORD_W-1:0] in_y,
    input  logic               in_last,
    input  logic               pop,
    output logic               head_valid,
    output logic               head_pixel,
    output logic [COORD_W-1:0] head_x,
    output logic [COORD_W-1:0] head_y,
    output logic               head_last,
    output logic [1:0]         count
);

    localparam int ENTRY_W = 2 + 2 * COORD_W;

    logic [ENTRY_W-1:0] head_reg;
    logic [ENTRY_W-1:0] tail_reg;
    logic [ENTRY_W-1:0] in_entry;
    logic [1:0]         count_reg;
    logic               pop_eff;

    assign in_entry = {in_pixel, in_last, in_x, in_y};
    // A pop on an empty FIFO is meaningless; ignore it rather than underflow.
    assign pop_eff  = pop && (count_reg != 2'd0);

    // Head/tail shifting: new data goes to the head when it is (or becomes) free.
    always_ff @(posedge clk) begin
        if (srst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= 2'd0;
        end else begin
            case ({push, pop_eff})
                2'b10: begin
                    if (count_reg == 2'd0) begin
                        head_reg <= in_entry;
                    end else begin
                        tail_reg <= in_entry;
                    end
                    count_reg <= count_reg + 2'd1;
                end
                2'b01: begin
                    head_reg  <= tail_reg;
                    count_reg <= count_reg - 2'd1;
                end
                2'b11: begin
                    if (count_reg == 2'd1) begin
                        head_reg <= in_entry;
                    end else begin
                        head_reg <= tail_reg;
                        tail_reg <= in_entry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign head_valid = (count_reg != 2'd0);
    assign head_pixel = head_reg[ENTRY_W-1];
    assign head_last  = head_reg[ENTRY_W-2];
    assign head_x     = head_reg[2*COORD_W-1:COORD_W];
    assign head_y     = head_reg[COORD_W-1:0];
    assign count      = count_reg;

endmodule

// File: rtl/canvas_reader.sv
// Scans the 1-bit canvas memory row-major and streams each cell to the
// inference stage as an 8-bit pixel, tracking set-cell count and bounding box.
// Reads are only issued when a FIFO slot is guaranteed for the returning data,
// so backpressure never loses a pixel.
module canvas_reader
    import canvas_pkg::*;
(
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic               rd_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_pixel,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic               out_last,
    output logic               done,
    output logic [COUNT_W-1:0] set_count,
    output logic [COORD_W-1:0] bbox_xmin,
    output logic [COORD_W-1:0] bbox_xmax,
    output logic [COORD_W-1:0] bbox_ymin,
    output logic [COORD_W-1:0] bbox_ymax,
    output logic               bbox_empty
);

    state_t              state_reg;
    logic                busy_reg;
    logic                done_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [COORD_W-1:0]  x_reg;
    logic [COORD_W-1:0]  y_reg;

    // Read in flight: its data is on rd_data this cycle and lands in the FIFO
    // at the next edge, carrying the coordinates it was issued with.
    logic                pend_valid_reg;
    logic [COORD_W-1:0]  pend_x_reg;
    logic [COORD_W-1:0]  pend_y_reg;
    logic                pend_last_reg;

    logic [COUNT_W-1:0]  set_count_reg;
    logic [COORD_W-1:0]  xmin_reg;
    logic [COORD_W-1:0]  xmax_reg;
    logic [COORD_W-1:0]  ymin_reg;
    logic [COORD_W-1:0]  ymax_reg;

    logic                head_valid;
    logic                head_pixel;
    logic [COORD_W-1:0]  head_x;
    logic [COORD_W-1:0]  head_y;
    logic                head_last;
    logic [1:0]          fifo_count;

    logic                handshake;
    logic [2:0]          committed;
    logic                issue;

    assign handshake = head_valid && out_ready;

    // Slots spoken for after this cycle's pop, plus the read still in flight.
    // Counting the same-cycle pop lets the pipeline sustain one pixel per cycle
    // with only two FIFO entries.
    assign committed = {1'b0, fifo_count} + {2'b00, pend_valid_reg} - {2'b00, handshake};
    assign issue     = (state_reg == ST_SCAN) && (committed < 3'd2);

    pixel_skid_fifo u_fifo (
        .clk        (CLOCK_50),
        .srst       (reset),
        .push       (pend_valid_reg),
        .in_pixel   (rd_data),
        .in_x       (pend_x_reg),
        .in_y       (pend_y_reg),
        .in_last    (pend_last_reg),
        .pop        (handshake),
        .head_valid (head_valid),
        .head_pixel (head_pixel),
        .head_x     (head_x),
        .head_y     (head_y),
        .head_last  (head_last),
        .count      (fifo_count)
    );

    // Scan FSM, incremental address/coordinate generation and running stats.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            addr_reg       <= '0;
            x_reg          <= '0;
            y_reg          <= '0;
            pend_valid_reg <= 1'b0;
            pend_x_reg     <= '0;
            pend_y_reg     <= '0;
            pend_last_reg  <= 1'b0;
            set_count_reg  <= '0;
            xmin_reg       <= BBOX_MIN_INIT;
            xmax_reg       <= BBOX_MAX_INIT;
            ymin_reg       <= BBOX_MIN_INIT;
            ymax_reg       <= BBOX_MAX_INIT;
        end else begin
            done_reg       <= 1'b0;
            pend_valid_reg <= issue;
            pend_x_reg     <= x_reg;
            pend_y_reg     <= y_reg;
            pend_last_reg  <= (addr_reg == LAST_ADDR);

            if (handshake && head_pixel) begin
                set_count_reg <= set_count_reg + COUNT_W'(1);
                if (head_x < xmin_reg) xmin_reg <= head_x;
                if (head_x > xmax_reg) xmax_reg <= head_x;
                if (head_y < ymin_reg) ymin_reg <= head_y;
                if (head_y > ymax_reg) ymax_reg <= head_y;
            end

            case (state_reg)
                ST_IDLE: begin
                    busy_reg <= 1'b0;
                    if (start) begin
                        state_reg     <= ST_SCAN;
                        busy_reg      <= 1'b1;
                        addr_reg      <= '0;
                        x_reg         <= '0;
                        y_reg         <= '0;
                        set_count_reg <= '0;
                        xmin_reg      <= BBOX_MIN_INIT;
                        xmax_reg      <= BBOX_MAX_INIT;
                        ymin_reg      <= BBOX_MIN_INIT;
                        ymax_reg      <= BBOX_MAX_INIT;
                    end
                end
                ST_SCAN: begin
                    if (issue) begin
                        addr_reg <= addr_reg + ADDR_W'(1);
                        if (x_reg == COORD_MAX) begin
                            x_reg <= '0;
                            y_reg <= y_reg + COORD_W'(1);
                        end else begin
                            x_reg <= x_reg + COORD_W'(1);
                        end
                        if (addr_reg == LAST_ADDR) begin
                            state_reg <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // busy stays high through the done cycle; IDLE drops it.
                    if (handshake && head_last) begin
                        state_reg <= ST_IDLE;
                        done_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_reg;
    assign done       = done_reg;
    assign rd_en      = issue;
    assign rd_addr    = addr_reg;
    assign out_valid  = head_valid;
    assign out_pixel  = head_pixel ? PIXEL_ON : PIXEL_OFF;
    assign out_x      = head_x;
    assign out_y      = head_y;
    assign out_last   = head_last;
    assign set_count  = set_count_reg;
    assign bbox_xmin  = xmin_reg;
    assign bbox_xmax  = xmax_reg;
    assign bbox_ymin  = ymin_reg;
    assign bbox_ymax  = ymax_reg;
    assign bbox_empty = (set_count_reg == '0);

endmodule

// File: tb/tb_canvas_reader.sv
// Directed bench for canvas_reader: a behavioural 1-cycle-latency canvas memory,
// scans under several ready patterns, and checks timing, ordering and stats.
module tb_canvas_reader;

    logic       clk;
    logic       reset;
    logic       start;
    logic       busy;
    logic       rd_en;
    logic [9:0] rd_addr;
    logic       rd_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_pixel;
    logic [4:0] out_x;
    logic [4:0] out_y;
    logic       out_last;
    logic       done;
    logic [9:0] set_count;
    logic [4:0] bbox_xmin;
    logic [4:0] bbox_xmax;
    logic [4:0] bbox_ymin;
    logic [4:0] bbox_ymax;
    logic       bbox_empty;

    int total = 0;
    int bad   = 0;

    logic mem [0:783];

    // Scan observations, filled by do_scan.
    int seq_err, stab_err, credit_err, n_out, done_cnt;
    int first_valid, last_cyc, done_cyc, busy_low, reads_at_100;
    int rd1_ok, busy1, scan_ok;
    int exp_cnt, exp_xmin, exp_xmax, exp_ymin, exp_ymax;

    canvas_reader dut (
        .CLOCK_50   (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pixel  (out_pixel),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_last   (out_last),
        .done       (done),
        .set_count  (set_count),
        .bbox_xmin  (bbox_xmin),
        .bbox_xmax  (bbox_xmax),
        .bbox_ymin  (bbox_ymin),
        .bbox_ymax  (bbox_ymax),
        .bbox_empty (bbox_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Canvas memory: data for the address presented with rd_en appears next cycle.
    always @(posedge clk) begin
        rd_data <= rd_en ? mem[int'(rd_addr)] : 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},      32'(busy),       32'd0);
        check({tag, "_rd_en"},     32'(rd_en),      32'd0);
        check({tag, "_rd_addr"},   32'(rd_addr),    32'd0);
        check({tag, "_out_valid"}, 32'(out_valid),  32'd0);
        check({tag, "_out_pixel"}, 32'(out_pixel),  32'd0);
        check({tag, "_out_x"},     32'(out_x),      32'd0);
        check({tag, "_out_y"},     32'(out_y),      32'd0);
        check({tag, "_out_last"},  32'(out_last),   32'd0);
        check({tag, "_done"},      32'(done),       32'd0);
        check({tag, "_set_count"}, 32'(set_count),  32'd0);
        check({tag, "_empty"},     32'(bbox_empty), 32'd1);
        check({tag, "_xmin"},      32'(bbox_xmin),  32'd31);
        check({tag, "_xmax"},      32'(bbox_xmax),  32'd0);
        check({tag, "_ymin"},      32'(bbox_ymin),  32'd31);
        check({tag, "_ymax"},      32'(bbox_ymax),  32'd0);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 784; i++) mem[i] = 1'b0;
    endtask

    // Reference stats from the memory image.
    task automatic compute_expect();
        exp_cnt = 0; exp_xmin = 31; exp_xmax = 0; exp_ymin = 31; exp_ymax = 0;
        for (int i = 0; i < 784; i++) begin
            if (mem[i]) begin
                exp_cnt++;
                if (i % 28 < exp_xmin) exp_xmin = i % 28;
                if (i % 28 > exp_xmax) exp_xmax = i % 28;
                if (i / 28 < exp_ymin) exp_ymin = i / 28;
                if (i / 28 > exp_ymax) exp_ymax = i / 28;
            end
        end
    endtask

    // mode 0: ready high; 1: ready random; 2: ready low through cycle 100;
    // 3: reset at cycle 400; 4: extra start pulse at cycle 200.
    // Cycle 0 is the cycle start is high; cycle n is n edges later.
    task automatic do_scan(input int mode);
        int n, idx, reads, outstanding, hs;
        logic prev_stall, pv_last;
        logic [7:0] pv_pix;
        logic [4:0] pv_x, pv_y;
        seq_err = 0; stab_err = 0; credit_err = 0; n_out = 0; done_cnt = 0;
        first_valid = -1; last_cyc = -1; done_cyc = -1; busy_low = -1;
        reads_at_100 = -1; rd1_ok = 0; busy1 = 0; scan_ok = 0;
        idx = 0; reads = 0; outstanding = 0; prev_stall = 1'b0;
        pv_pix = '0; pv_x = '0; pv_y = '0; pv_last = 1'b0;
        @(negedge clk);
        out_ready = (mode == 0 || mode == 3 || mode == 4);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (scan_ok == 0 && n < 4000) begin
            case (mode)
                1: out_ready = ($urandom_range(0, 1) == 1);
                2: out_ready = (n > 100);
                default: out_ready = 1'b1;
            endcase
            start = (mode == 4 && n == 200);
            if (mode == 3 && n == 400) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                #1;
                check_reset_vals("midscan_reset");
                return;
            end
            #1;
            hs = (out_valid && out_ready) ? 1 : 0;
            if (n == 1) begin
                rd1_ok = (rd_en && rd_addr == 10'd0) ? 1 : 0;
                busy1 = busy ? 1 : 0;
            end
            if (rd_en) begin
                if (outstanding - hs >= 2) credit_err++;
                reads++;
            end
            if (n == 100) reads_at_100 = reads;
            if (mode == 2 && n == 100) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_x", 32'(out_x), 32'd0);
                check("stall_y", 32'(out_y), 32'd0);
            end
            if (prev_stall && (!out_valid || out_pixel !== pv_pix || out_x !== pv_x ||
                               out_y !== pv_y || out_last !== pv_last)) stab_err++;
            if (out_valid && first_valid < 0) first_valid = n;
            if (hs == 1) begin
                if (idx >= 784 || out_x !== 5'(idx % 28) || out_y !== 5'(idx / 28) ||
                    out_pixel !== (mem[idx] ? 8'd255 : 8'd0) || out_last !== (idx == 783))
                    seq_err++;
                if (out_last) last_cyc = n;
                idx++;
                n_out++;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = n;
            end
            if (done_cyc >= 0 && !busy && busy_low < 0) busy_low = n;
            if (busy_low >= 0 && n > done_cyc + 4) scan_ok = 1;
            outstanding = outstanding + (rd_en ? 1 : 0) - hs;
            prev_stall = out_valid && !out_ready;
            pv_pix = out_pixel; pv_x = out_x; pv_y = out_y; pv_last = out_last;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        out_ready = 1'b1;
        check("scan_completed", 32'(scan_ok), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        clear_mem();
        repeat (3) @(negedge clk);
        #1;
        // Reset state, with start held alongside reset: reset must win.
        start = 1'b1;
        @(negedge clk);
        #1;
        check_reset_vals("reset");
        start = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Empty canvas, ready high: exact cycle timing.
        do_scan(0);
        check("empty_rd1", 32'(rd1_ok), 32'd1);
        check("empty_busy1", 32'(busy1), 32'd1);
        check("empty_first_valid", 32'(first_valid), 32'd3);
        check("empty_last_cyc", 32'(last_cyc), 32'd786);
        check("empty_done_cyc", 32'(done_cyc), 32'd787);
        check("empty_busy_low", 32'(busy_low), 32'd788);
        check("empty_n_out", 32'(n_out), 32'd784);
        check("empty_seq", 32'(seq_err), 32'd0);
        check("empty_done_cnt", 32'(done_cnt), 32'd1);
        check("empty_count", 32'(set_count), 32'd0);
        check("empty_flag", 32'(bbox_empty), 32'd1);
        check("empty_xmin", 32'(bbox_xmin), 32'd31);
        check("empty_xmax", 32'(bbox_xmax), 32'd0);

        // Three cells: (3,5), (20,5), (10,22).
        clear_mem();
        mem[5*28+3] = 1'b1;
        mem[5*28+20] = 1'b1;
        mem[22*28+10] = 1'b1;
        do_scan(0);
        check("three_seq", 32'(seq_err), 32'd0);
        check("three_count", 32'(set_count), 32'd3);
        check("three_flag", 32'(bbox_empty), 32'd0);
        check("three_xmin", 32'(bbox_xmin), 32'd3);
        check("three_xmax", 32'(bbox_xmax), 32'd20);
        check("three_ymin", 32'(bbox_ymin), 32'd5);
        check("three_ymax", 32'(bbox_ymax), 32'd22);

        // Random canvas, random backpressure.
        for (int i = 0; i < 784; i++) mem[i] = ($urandom_range(0, 3) == 0);
        compute_expect();
        do_scan(1);
        check("rand_n_out", 32'(n_out), 32'd784);
        check("rand_seq", 32'(seq_err), 32'd0);
        check("rand_stable", 32'(stab_err), 32'd0);
        check("rand_credit", 32'(credit_err), 32'd0);
        check("rand_done_cnt", 32'(done_cnt), 32'd1);
        check("rand_count", 32'(set_count), 32'(exp_cnt));
        check("rand_xmin", 32'(bbox_xmin), 32'(exp_xmin));
        check("rand_xmax", 32'(bbox_xmax), 32'(exp_xmax));
        check("rand_ymin", 32'(bbox_ymin), 32'(exp_ymin));
        check("rand_ymax", 32'(bbox_ymax), 32'(exp_ymax));

        // Full canvas, held off for 100 cycles after start.
        for (int i = 0; i < 784; i++) mem[i] = 1'b1;
        do_scan(2);
        check("full_reads_stalled", 32'(reads_at_100), 32'd2);
        check("full_stable", 32'(stab_err), 32'd0);
        check("full_n_out", 32'(n_out), 32'd784);
        check("full_seq", 32'(seq_err), 32'd0);
        check("full_count", 32'(set_count), 32'd784);
        check("full_xmin", 32'(bbox_xmin), 32'd0);
        check("full_xmax", 32'(bbox_xmax), 32'd27);
        check("full_ymin", 32'(bbox_ymin), 32'd0);
        check("full_ymax", 32'(bbox_ymax), 32'd27);

        // Reset partway through a scan, then a fresh scan from (0,0).
        do_scan(3);
        repeat (3) @(negedge clk);
        check("post_reset_valid", 32'(out_valid), 32'd0);
        clear_mem();
        mem[5*28+3] = 1'b1;
        mem[5*28+20] = 1'b1;
        mem[22*28+10] = 1'b1;
        do_scan(0);
        check("rescan_first_valid", 32'(first_valid), 32'd3);
        check("rescan_n_out", 32'(n_out), 32'd784);
        check("rescan_seq", 32'(seq_err), 32'd0);
        check("rescan_count", 32'(set_count), 32'd3);
        check("rescan_xmin", 32'(bbox_xmin), 32'd3);

        // A start pulse in the middle of a scan is ignored.
        do_scan(4);
        check("restart_done_cnt", 32'(done_cnt), 32'd1);
        check("restart_done_cyc", 32'(done_cyc), 32'd787);
        check("restart_n_out", 32'(n_out), 32'd784);
        check("restart_count", 32'(set_count), 32'd3);
        repeat (3) @(negedge clk);
        check("restart_idle_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/canvas_reader.md
# canvas_reader

Reads the 28×28 1-bit drawing canvas back out of pixel memory and streams it, row-major, to the neural-network input stage over a valid/ready interface. It computes set-pixel count and bounding box on the fly. It is the consumer-side counterpart to the cursor/draw logic that writes the canvas. It sits between the canvas memory's read port and the inference datapath, and is triggered once per classification request.

## Interface
- GRID_SIZE, 28, canvas side length in cells
- NUM_PIXELS, 784, GRID_SIZE*GRID_SIZE
- ADDR_W, 10, pixel memory address width
- PIXEL_ON, 8'd255, output value for a set cell
- PIXEL_OFF, 8'd0, output value for a clear cell

Ports:
- CLOCK_50  in  1  sole clock
- reset  in  1  synchronous, active-high
- start  in  1  begin one full scan; sampled only in IDLE
- busy  out  1  high from cycle after start accepted until done pulse
- rd_en  out  1  memory read strobe
- rd_addr  out  ADDR_W  read address, y*GRID_SIZE+x
- rd_data  in  1  cell value, valid exactly 1 cycle after rd_en
- out_valid  out  1  pixel available
- out_ready  in  1  downstream accepts
- out_pixel  out  8  PIXEL_ON/PIXEL_OFF
- out_x, out_y  out  5 each  cell coordinate of out_pixel
- out_last  out  1  high with pixel 783 (x=27,y=27)
- done  out  1  one-cycle pulse after last handshake
- set_count  out  10  number of set cells in last scan
- bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax  out  5 each  bounding box of set cells
- bbox_empty  out  1  set_count==0

## Operation
- States: IDLE → SCAN → DRAIN → IDLE.
- IDLE: start=1 → clear set_count, bbox (xmin=ymin=31, xmax=ymax=0), read pointer=0; go SCAN. Start while not IDLE is ignored.
- SCAN: issue rd_en with rd_addr=pointer when (fifo occupancy + in-flight reads) < 2; pointer increments per issue. After issuing addr 783 → DRAIN.
- DRAIN: no further reads; leave when the handshake on out_last completes, then pulse done and return to IDLE.
- Returned rd_data enters a 2-entry FIFO tagged with x,y. A read is never issued that cannot land, so no data is dropped under backpressure.
- Address generation uses separate x (0..27) and y counters. x wraps 27→0 with y+1; no divider or multiplier on rd_addr (incremental).
- On each handshake (out_valid && out_ready) with cell set: set_count+1; bbox min/max updated with out_x/out_y.
- Stats hold after done until next accepted start. bbox_empty = (set_count==0). When empty, the bbox registers read xmin=ymin=31, xmax=ymax=0.
- out_valid must not drop and out_pixel/out_x/out_y/out_last must not change while out_valid && !out_ready.

## Timing
- Reset values: busy=0, rd_en=0, rd_addr=0, out_valid=0, out_pixel=0, out_x=out_y=0, out_last=0, done=0, set_count=0, bbox_empty=1, xmin=ymin=31, xmax=ymax=0. State=IDLE; FIFO empty; in-flight read discarded.
- start in cycle 0 → rd_en=1, addr 0 in cycle 1 → rd_data in cycle 2 → out_valid=1 for (0,0) in cycle 3.
- out_ready held high: one pixel per cycle; out_last in cycle 786; done=1 in cycle 787; busy low in cycle 788.
- Reset asserted mid-scan: next cycle all outputs at reset values regardless of handshake state.
- start and reset in the same cycle: reset wins.
- set_count max 784 fits 10 bits; no saturation needed.

## Structure
- Package canvas_pkg: GRID_SIZE, NUM_PIXELS, ADDR_W, COORD_W=5, PIXEL_ON/PIXEL_OFF, state encoding. The canvas writer imports the same constants.
- Sub-module pixel_skid_fifo: 2-entry FIFO of {pixel, x, y, last}, with occupancy output used for read-issue credit.

## Test plan
- Empty canvas, out_ready=1: 784 outputs all 0; out_last at (27,27); done at cycle 787; set_count=0, bbox_empty=1.
- Cells (3,5),(20,5),(10,22) set: out_pixel=255 exactly at those coords; set_count=3; bbox x 3..20, y 5..22.
- out_ready toggled random 50%: the output sequence matches the memory contents in order. No duplicate or missing index. Outputs are stable while stalled. rd_en never issued with 2 entries committed.
- Full canvas with out_ready low for 100 cycles after start: out_valid=1 holding (0,0); exactly 2 reads issued. Then release: 784 outputs, set_count=784, bbox 0..27.
- Reset at cycle 400 of a scan: outputs at reset values next cycle. A new start then yields a complete scan from (0,0) with fresh stats.
- start pulsed during SCAN: ignored; single done, set_count unaffected.
